// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular FIFO that compacts valid fetch lanes
// and issues up to ISSUE_WIDTH entries in order. Optional bypass: IF_ID_QUEUE_BYPASS_EN.
module if_id_queue #(
   parameter int FETCH_WIDTH = 2,
   parameter int ISSUE_WIDTH = 2,
   parameter int DEPTH       = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      branch_flag_i,
   input  logic [FETCH_WIDTH-1:0]    if_valid_i,
   input  logic [32*FETCH_WIDTH-1:0] if_pc_i,
   input  logic [32*FETCH_WIDTH-1:0] if_inst_i,
   input  logic [FETCH_WIDTH-1:0]    excp_i,
   input  logic [4*FETCH_WIDTH-1:0]  excp_num_i,
   output logic                      if_ready_o,
   output logic [ISSUE_WIDTH-1:0]    id_valid_o,
   input  logic [ISSUE_WIDTH-1:0]    id_ready_i,
   output logic [32*ISSUE_WIDTH-1:0] id_pc_o,
   output logic [32*ISSUE_WIDTH-1:0] id_inst_o,
   output logic [ISSUE_WIDTH-1:0]    excp_o,
   output logic [4*ISSUE_WIDTH-1:0]  excp_num_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic [31:0] r_pc       [DEPTH];
   logic [31:0] r_inst     [DEPTH];
   logic        r_excp     [DEPTH];
   logic [3:0]  r_excp_num [DEPTH];

   logic [CNT_W-1:0] w_off  [FETCH_WIDTH];
   logic [CNT_W-1:0] w_nvalid;
   logic [31:0]      w_cpc  [FETCH_WIDTH];
   logic [31:0]      w_cinst[FETCH_WIDTH];
   logic             w_cexcp[FETCH_WIDTH];
   logic [3:0]       w_cnum [FETCH_WIDTH];

   logic             w_byp;
   logic             w_push_en;
   logic [CNT_W-1:0] w_pop;
   logic [CNT_W-1:0] w_skip;
   logic [CNT_W-1:0] w_pushed;
   logic [CNT_W-1:0] w_popped;
   logic             w_wr_en [FETCH_WIDTH];
   logic [PTR_W-1:0] w_wr_idx[FETCH_WIDTH];

   assign if_ready_o = (r_count <= CNT_W'(DEPTH - FETCH_WIDTH));
   assign w_push_en  = if_ready_o & ~flush & ~branch_flag_i;

`ifdef IF_ID_QUEUE_BYPASS_EN
   assign w_byp = (r_count == '0) & ~flush & ~branch_flag_i;
`else
   assign w_byp = 1'b0;
`endif

   // Compact valid fetch lanes into consecutive positions (lane order preserved)
   always_comb begin
      logic [CNT_W-1:0] v_off;
      v_off = '0;
      for (int l = 0; l < FETCH_WIDTH; l++) begin
         w_off[l] = v_off;
         v_off    = v_off + CNT_W'(if_valid_i[l]);
      end
      w_nvalid = v_off;
      for (int j = 0; j < FETCH_WIDTH; j++) begin
         w_cpc[j]   = 32'h0;
         w_cinst[j] = 32'h0;
         w_cexcp[j] = 1'b0;
         w_cnum[j]  = 4'h0;
         for (int l = 0; l < FETCH_WIDTH; l++) begin
            if (if_valid_i[l] && (w_off[l] == CNT_W'(j))) begin
               w_cpc[j]   = if_pc_i[32*l +: 32];
               w_cinst[j] = if_inst_i[32*l +: 32];
               w_cexcp[j] = excp_i[l];
               w_cnum[j]  = excp_num_i[4*l +: 4];
            end else begin
               w_cpc[j] = w_cpc[j];
            end
         end
      end
   end

   // Drive issue slots from stored entries, or from compacted inputs when bypassing
   always_comb begin
      id_valid_o = '0;
      id_pc_o    = '0;
      id_inst_o  = '0;
      excp_o     = '0;
      excp_num_o = '0;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         if (w_byp) begin
            if ((k < FETCH_WIDTH) && (CNT_W'(k) < w_nvalid)) begin
               id_valid_o[k]       = 1'b1;
               id_pc_o[32*k +: 32] = w_cpc[k % FETCH_WIDTH];
               id_inst_o[32*k +: 32] = w_cinst[k % FETCH_WIDTH];
               excp_o[k]           = w_cexcp[k % FETCH_WIDTH];
               excp_num_o[4*k +: 4] = w_cnum[k % FETCH_WIDTH];
            end else begin
               id_valid_o[k] = 1'b0;
            end
         end else if (CNT_W'(k) < r_count) begin
            id_valid_o[k]         = 1'b1;
            id_pc_o[32*k +: 32]   = r_pc[r_head + PTR_W'(k)];
            id_inst_o[32*k +: 32] = r_inst[r_head + PTR_W'(k)];
            excp_o[k]             = r_excp[r_head + PTR_W'(k)];
            excp_num_o[4*k +: 4]  = r_excp_num[r_head + PTR_W'(k)];
         end else begin
            id_valid_o[k] = 1'b0;
         end
      end
   end

   // Pop only the unbroken run of accepted slots starting at slot 0
   always_comb begin
      logic v_run;
      v_run = 1'b1;
      w_pop = '0;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         if (v_run && id_valid_o[k] && id_ready_i[k]) begin
            w_pop = w_pop + CNT_W'(1);
         end else begin
            v_run = 1'b0;
         end
      end
   end

   // Bypassed lanes taken by decode are never written; stored pops only outside bypass
   always_comb begin
      w_skip   = w_byp ? w_pop : '0;
      w_popped = w_byp ? '0 : w_pop;
      w_pushed = w_push_en ? (w_nvalid - w_skip) : '0;
      for (int j = 0; j < FETCH_WIDTH; j++) begin
         w_wr_en[j]  = w_push_en && (CNT_W'(j) >= w_skip) && (CNT_W'(j) < w_nvalid);
         w_wr_idx[j] = r_tail + PTR_W'(CNT_W'(j) - w_skip);
      end
   end

   // Pointer and occupancy state; reset beats flush beats push/pop
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + PTR_W'(w_popped);
         r_tail  <= r_tail + PTR_W'(w_pushed);
         r_count <= r_count + w_pushed - w_popped;
      end
   end

   // Entry storage; contents are only observable through valid slots
   always_ff @(posedge clk) begin
      for (int j = 0; j < FETCH_WIDTH; j++) begin
         if (!rst && w_wr_en[j]) begin
            r_pc[w_wr_idx[j]]       <= w_cpc[j];
            r_inst[w_wr_idx[j]]     <= w_cinst[j];
            r_excp[w_wr_idx[j]]     <= w_cexcp[j];
            r_excp_num[w_wr_idx[j]] <= w_cnum[j];
         end
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (default parameters, no bypass).
module tb_if_id_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        branch_flag_i;
   logic [1:0]  if_valid_i;
   logic [63:0] if_pc_i;
   logic [63:0] if_inst_i;
   logic [1:0]  excp_i;
   logic [7:0]  excp_num_i;
   logic        if_ready_o;
   logic [1:0]  id_valid_o;
   logic [1:0]  id_ready_i;
   logic [63:0] id_pc_o;
   logic [63:0] id_inst_o;
   logic [1:0]  excp_o;
   logic [7:0]  excp_num_o;

   int n_checks = 0;
   int n_pass   = 0;

   if_id_queue #(.FETCH_WIDTH(2), .ISSUE_WIDTH(2), .DEPTH(8)) dut (
      .clk(clk), .rst(rst), .flush(flush), .branch_flag_i(branch_flag_i),
      .if_valid_i(if_valid_i), .if_pc_i(if_pc_i), .if_inst_i(if_inst_i),
      .excp_i(excp_i), .excp_num_i(excp_num_i), .if_ready_o(if_ready_o),
      .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_pc_o(id_pc_o),
      .id_inst_o(id_inst_o), .excp_o(excp_o), .excp_num_o(excp_num_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      flush = 1'b0; branch_flag_i = 1'b0; if_valid_i = 2'b00;
      if_pc_i = 64'h0; if_inst_i = 64'h0; excp_i = 2'b00; excp_num_i = 8'h00;
      id_ready_i = 2'b00;
   endtask

   task automatic group(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
      if_valid_i = v;
      if_pc_i    = {pc1, pc0};
      if_inst_i  = {pc1 ^ 32'hA5A5_0000, pc0 ^ 32'hA5A5_0000};
   endtask

   initial begin
      logic [31:0] exp_lo [4];
      logic [31:0] exp_hi [4];
      exp_lo[0] = 32'h0000_0110; exp_hi[0] = 32'h0000_0114;
      exp_lo[1] = 32'h0000_0118; exp_hi[1] = 32'h0000_011C;
      exp_lo[2] = 32'h0000_0200; exp_hi[2] = 32'h0000_0204;
      exp_lo[3] = 32'h0000_0208; exp_hi[3] = 32'h0000_020C;

      // Reset and idle
      idle_in();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_valid", {62'h0, id_valid_o}, 64'h0);
      chk("rst_ready", {63'h0, if_ready_o}, 64'h1);
      chk("rst_pc", id_pc_o, 64'h0);
      chk("rst_inst", id_inst_o, 64'h0);
      chk("rst_excp", {62'h0, excp_o}, 64'h0);
      chk("rst_excp_num", {56'h0, excp_num_o}, 64'h0);

      // Two-lane push with exception on lane 1, held, then popped
      group(2'b11, 32'h1C00_0000, 32'h1C00_0004);
      excp_i = 2'b10; excp_num_i = 8'hE0;
      tick();
      idle_in();
      #1;
      chk("push2_valid", {62'h0, id_valid_o}, 64'h3);
      chk("push2_pc", id_pc_o, 64'h1C00_0004_1C00_0000);
      chk("push2_inst", id_inst_o, 64'hB9A5_0004_B9A5_0000);
      chk("push2_excp", {62'h0, excp_o}, 64'h2);
      chk("push2_excp_num", {56'h0, excp_num_o}, 64'hE0);
      id_ready_i = 2'b11;
      tick();
      id_ready_i = 2'b00;
      chk("pop2_valid", {62'h0, id_valid_o}, 64'h0);
      chk("pop2_pc", id_pc_o, 64'h0);

      // Only lane 1 valid: compacted into one entry
      group(2'b10, 32'hDEAD_BEEF, 32'h1C00_0014);
      tick();
      idle_in();
      #1;
      chk("lane1_valid", {62'h0, id_valid_o}, 64'h1);
      chk("lane1_pc", id_pc_o, 64'h0000_0000_1C00_0014);
      id_ready_i = 2'b01;
      tick();
      id_ready_i = 2'b00;
      chk("lane1_pop", {62'h0, id_valid_o}, 64'h0);

      // Fill all 8 entries
      for (int g = 0; g < 4; g++) begin
         group(2'b11, 32'h100 + 32'(8*g), 32'h104 + 32'(8*g));
         tick();
      end
      idle_in();
      #1;
      chk("full_ready", {63'h0, if_ready_o}, 64'h0);
      group(2'b11, 32'h0000_0900, 32'h0000_0904);
      tick();
      idle_in();
      #1;
      chk("full_drop_ready", {63'h0, if_ready_o}, 64'h0);
      chk("full_drop_pc", id_pc_o, 64'h0000_0104_0000_0100);
      id_ready_i = 2'b11;
      tick();
      chk("after_pop_ready", {63'h0, if_ready_o}, 64'h1);
      chk("after_pop_pc", id_pc_o, 64'h0000_010C_0000_0108);

      // Simultaneous push and pop across the pointer wrap
      for (int g = 0; g < 4; g++) begin
         group(2'b11, 32'h200 + 32'(8*g), 32'h204 + 32'(8*g));
         id_ready_i = 2'b11;
         tick();
         chk("wrap_pc", id_pc_o, {exp_hi[g], exp_lo[g]});
      end
      idle_in();
      #1;
      chk("wrap_valid", {62'h0, id_valid_o}, 64'h3);

      // Slot 1 ready without slot 0: no pop
      id_ready_i = 2'b10;
      tick();
      chk("noorder_valid", {62'h0, id_valid_o}, 64'h3);
      chk("noorder_pc", id_pc_o, 64'h0000_020C_0000_0208);
      id_ready_i = 2'b01;
      tick();
      id_ready_i = 2'b00;
      chk("pop1_pc", id_pc_o, 64'h0000_0210_0000_020C);

      // Branch drops the group and keeps the five stored entries
      branch_flag_i = 1'b1;
      group(2'b11, 32'h0000_0300, 32'h0000_0304);
      tick();
      idle_in();
      #1;
      chk("branch_valid", {62'h0, id_valid_o}, 64'h3);
      chk("branch_pc", id_pc_o, 64'h0000_0210_0000_020C);
      chk("branch_ready", {63'h0, if_ready_o}, 64'h1);

      // Flush at count 5 with a push and a pop in the same cycle
      flush = 1'b1;
      group(2'b11, 32'h0000_0400, 32'h0000_0404);
      id_ready_i = 2'b11;
      tick();
      idle_in();
      #1;
      chk("flush_valid", {62'h0, id_valid_o}, 64'h0);
      chk("flush_pc", id_pc_o, 64'h0);
      chk("flush_ready", {63'h0, if_ready_o}, 64'h1);

      // Queue usable after flush
      group(2'b11, 32'h0000_0500, 32'h0000_0504);
      tick();
      idle_in();
      #1;
      chk("postflush_pc", id_pc_o, 64'h0000_0504_0000_0500);

      // Reset overrides a concurrent push and pop
      rst = 1'b1;
      group(2'b11, 32'h0000_0600, 32'h0000_0604);
      id_ready_i = 2'b11;
      tick();
      rst = 1'b0;
      idle_in();
      #1;
      chk("rst_mid_valid", {62'h0, id_valid_o}, 64'h0);
      chk("rst_mid_ready", {63'h0, if_ready_o}, 64'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameters: FETCH_WIDTH, default 2, instructions delivered per fetch group; ISSUE_WIDTH, default 2, decode slots; DEPTH, default 8, queue entries, power of two, >= FETCH_WIDTH.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  pipeline flush.
- branch_flag_i  in  1  drop the current fetch group.
- if_valid_i  in  FETCH_WIDTH  per-lane instruction valid.
- if_pc_i  in  32*FETCH_WIDTH  lane PCs, lane 0 in the LSBs.
- if_inst_i  in  32*FETCH_WIDTH  lane instructions.
- excp_i  in  FETCH_WIDTH  per-lane fetch exception flag.
- excp_num_i  in  4*FETCH_WIDTH  per-lane exception code.
- if_ready_o  out  1  queue can accept a full group.
- id_valid_o  out  ISSUE_WIDTH  slot valid.
- id_ready_i  in  ISSUE_WIDTH  decode accepts slot.
- id_pc_o  out  32*ISSUE_WIDTH  slot PC.
- id_inst_o  out  32*ISSUE_WIDTH  slot instruction.
- excp_o  out  ISSUE_WIDTH  slot exception flag.
- excp_num_o  out  4*ISSUE_WIDTH  slot exception code.

Function
REQ-003 SHALL be a circular FIFO of DEPTH entries {pc, inst, excp, excp_num}, with head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH, and an occupancy count of log2(DEPTH)+1 bits.
REQ-004 SHALL drive if_ready_o = 1 iff (DEPTH - count) >= FETCH_WIDTH; this is combinational from registered count only.
REQ-005 Push: when if_ready_o=1, flush=0 and branch_flag_i=0, the queue SHALL write the lanes with if_valid_i=1 in ascending lane order, compacted into consecutive tail entries; invalid lanes leave no holes.
REQ-006 When if_ready_o=0 or branch_flag_i=1, the incoming group SHALL be discarded; upstream holds its group while if_ready_o=0.
REQ-007 Slot k output SHALL be entry (head+k) mod DEPTH; id_valid_o[k]=1 iff k < count; invalid slots SHALL drive pc, inst, excp and excp_num as zero.
REQ-008 Pop count SHALL equal the number of consecutive slots from slot 0 with id_valid_o & id_ready_i; a ready slot above an unaccepted slot SHALL NOT be popped, preserving in-order issue.
REQ-009 Push and pop SHALL occur in the same cycle; count_next = count + pushed - popped; the push check uses pre-pop count.
REQ-010 Latency push-to-visible SHALL be 1 cycle (registered storage; bypass per REQ-015).
REQ-011 flush=1 SHALL empty the queue next cycle (head=tail=count=0); same-cycle push and pop are ignored; flush has priority over branch_flag_i, push and pop.
REQ-012 Stored entries SHALL be read out unchanged; the block SHALL NOT alter exception fields.

Reset
REQ-013 rst=1 SHALL set head, tail and count to 0 at the next clk edge; all id_* and excp outputs then read 0, and if_ready_o reads 1.
REQ-014 rst SHALL take priority over flush and all other inputs, including mid-push and mid-pop.

Configuration
REQ-015 IF_ID_QUEUE_BYPASS_EN defined: when count=0, flush=0 and branch_flag_i=0, the valid input lanes, compacted, SHALL appear combinationally on the id_* slots in the same cycle; lanes accepted by decode are not written, and the rest are written per REQ-005. Undefined: no bypass, and minimum latency is 1 cycle.

Verification
REQ-016 Reset then idle -> id_valid_o=00, if_ready_o=1, all id outputs 0.
REQ-017 Push {pc 0x1c000000, 0x1c000004} with both lanes valid and id_ready_i=00, then raise id_ready_i=11 -> next cycle slots show those PCs in order, valid=11; after the pop, valid=00.
REQ-018 if_valid_i=10 with lane1 pc 0x1c000014 -> stored as a single entry; slot 0 shows 0x1c000014 and valid=01.
REQ-019 Fill 8 entries with DEPTH=8 -> if_ready_o=0 and a further group is dropped; pop 2 -> if_ready_o=1; 4 more groups confirm pointer wrap and ordering.
REQ-020 id_ready_i=10 with 2 valid slots -> no pop, count unchanged.
REQ-021 flush together with a push and a pop at count=5 -> next cycle count=0 and valid=00; with branch_flag_i only, the group is dropped and existing entries are kept.
